// File: rtl/player_countdown.sv
// Per-player chess-clock countdown: loads a BCD mm:ss preset from the one-hot
// time-control strobes and counts it down one second per tick while active.
module player_countdown (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic [7:0] SEL,
  input  logic       ACTIVE,
  input  logic       TICK,
  output logic [3:0] MIN_T,
  output logic [3:0] MIN_U,
  output logic [3:0] SEC_T,
  output logic [3:0] SEC_U,
  output logic       RUNNING,
  output logic       LOW_TIME,
  output logic       EXPIRED
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READY   = 2'd1,
    ST_RUN     = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [15:0] time_r, time_nxt_s;
  logic        running_r, low_time_r, expired_r;
  logic        low_nxt_s;

  // Lowest set strobe selects the preset; time packed as {MIN_T,MIN_U,SEC_T,SEC_U}.
  function automatic logic [15:0] preset_bcd(input logic [7:0] sel);
    logic [15:0] p;
    if (sel[0])      p = 16'h0100;
    else if (sel[1]) p = 16'h0300;
    else if (sel[2]) p = 16'h0500;
    else if (sel[3]) p = 16'h1000;
    else if (sel[4]) p = 16'h1500;
    else if (sel[5]) p = 16'h3000;
    else if (sel[6]) p = 16'h6000;
    else if (sel[7]) p = 16'h9000;
    else             p = 16'h0000;
    return p;
  endfunction

  function automatic logic [15:0] dec_bcd(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          mt = (mt != 4'd0) ? mt - 4'd1 : 4'd0;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  // Next state and next time value.
  always_comb begin
    state_nxt_s = state_r;
    time_nxt_s  = time_r;
    if (CE) begin
      case (state_r)
        ST_IDLE, ST_READY, ST_EXPIRED: begin
          if (SEL != 8'd0) begin
            state_nxt_s = ST_READY;
            time_nxt_s  = preset_bcd(SEL);
          end else if ((state_r == ST_READY) && ACTIVE) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_RUN: begin
          // Pause beats a coincident tick; a zero count expires without a tick.
          if (!ACTIVE) begin
            state_nxt_s = ST_READY;
          end else if (time_r == 16'h0000) begin
            state_nxt_s = ST_EXPIRED;
          end else if (TICK) begin
            if (time_r == 16'h0001) begin
              state_nxt_s = ST_EXPIRED;
              time_nxt_s  = 16'h0000;
            end else begin
              time_nxt_s  = dec_bcd(time_r);
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          time_nxt_s  = 16'h0000;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
    low_nxt_s = ((state_nxt_s == ST_READY) || (state_nxt_s == ST_RUN)) &&
                (time_nxt_s[15:4] == 12'h000) && (time_nxt_s[3:0] != 4'd0);
  end

  // State, digits and flags all registered so outputs carry no input path.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_r    <= ST_IDLE;
      time_r     <= 16'h0000;
      running_r  <= 1'b0;
      low_time_r <= 1'b0;
      expired_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      time_r     <= time_nxt_s;
      running_r  <= (state_nxt_s == ST_RUN);
      low_time_r <= low_nxt_s;
      expired_r  <= (state_nxt_s == ST_EXPIRED);
    end
  end

  assign {MIN_T, MIN_U, SEC_T, SEC_U} = time_r;
  assign RUNNING  = running_r;
  assign LOW_TIME = low_time_r;
  assign EXPIRED  = expired_r;

endmodule

// File: tb/tb_player_countdown.sv
// Self-checking bench for player_countdown: directed scenarios plus random
// stimulus checked against a seconds-based reference model.
module tb_player_countdown;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       CE = 1'b0;
  logic [7:0] SEL = 8'd0;
  logic       ACTIVE = 1'b0;
  logic       TICK = 1'b0;
  logic [3:0] MIN_T, MIN_U, SEC_T, SEC_U;
  logic       RUNNING, LOW_TIME, EXPIRED;

  int checks = 0;
  int errors = 0;

  localparam int M_IDLE = 0, M_READY = 1, M_RUN = 2, M_EXP = 3;
  int m_mode = M_IDLE;
  int m_secs = 0;
  int preset_tbl [8] = '{60, 180, 300, 600, 900, 1800, 3600, 5400};

  player_countdown dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .SEL(SEL), .ACTIVE(ACTIVE), .TICK(TICK),
    .MIN_T(MIN_T), .MIN_U(MIN_U), .SEC_T(SEC_T), .SEC_U(SEC_U),
    .RUNNING(RUNNING), .LOW_TIME(LOW_TIME), .EXPIRED(EXPIRED)
  );

  always #5 CLK = ~CLK;

  function automatic int preset_secs(input logic [7:0] sel);
    for (int i = 0; i < 8; i++) if (sel[i]) return preset_tbl[i];
    return 0;
  endfunction

  // Model behaviour in whole seconds for one enabled clock edge.
  task automatic model_step(input logic ce, input logic [7:0] sel, input logic act, input logic tk);
    if (ce) begin
      if (m_mode != M_RUN && sel != 8'd0) begin
        m_mode = M_READY;
        m_secs = preset_secs(sel);
      end else if (m_mode == M_READY && act) begin
        m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        if (!act) m_mode = M_READY;
        else if (m_secs == 0) m_mode = M_EXP;
        else if (tk) begin
          m_secs = m_secs - 1;
          if (m_secs == 0) m_mode = M_EXP;
        end
      end
    end
  endtask

  function automatic logic [18:0] exp_vec();
    logic [3:0] mt, mu, st, su;
    logic low;
    mt = 4'((m_secs / 60) / 10);
    mu = 4'((m_secs / 60) % 10);
    st = 4'((m_secs % 60) / 10);
    su = 4'((m_secs % 60) % 10);
    low = (m_mode == M_READY || m_mode == M_RUN) && m_secs >= 1 && m_secs <= 9;
    return {mt, mu, st, su, (m_mode == M_RUN), low, (m_mode == M_EXP)};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {MIN_T, MIN_U, SEC_T, SEC_U, RUNNING, LOW_TIME, EXPIRED};
  endfunction

  function automatic logic [15:0] dut_digits();
    return {MIN_T, MIN_U, SEC_T, SEC_U};
  endfunction

  // Drive one cycle's inputs, advance past the edge, update the model.
  task automatic cyc(input logic ce, input logic [7:0] sel, input logic act, input logic tk);
    CE = ce; SEL = sel; ACTIVE = act; TICK = tk;
    @(posedge CLK);
    model_step(ce, sel, act, tk);
    #1;
  endtask

  task automatic test_reset();
    CLR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (dut_vec() !== 19'd0) begin
      errors++; $display("FAIL reset_init: got %h expected %h", dut_vec(), 19'd0);
    end
    @(negedge CLK); CLR = 1'b1;
    @(posedge CLK); #1;
    cyc(1'b1, 8'h04, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h00, 1'b1, 1'b1);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_prerun: got %h expected %h", dut_vec(), exp_vec());
    end
    #2 CLR = 1'b0;
    m_mode = M_IDLE; m_secs = 0;
    #1;
    checks++;
    if (dut_vec() !== 19'd0) begin
      errors++; $display("FAIL reset_async: got %h expected %h", dut_vec(), 19'd0);
    end
    @(negedge CLK); CLR = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'h00, 1'b1, 1'b1);
      checks++;
      if (dut_vec() !== 19'd0) begin
        errors++; $display("FAIL reset_idle_hold: got %h expected %h", dut_vec(), 19'd0);
      end
    end
  endtask

  task automatic test_load();
    cyc(1'b1, 8'h04, 1'b0, 1'b0);
    checks++;
    if (dut_digits() !== 16'h0500 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL load_05: got %h expected %h", dut_vec(), exp_vec());
    end
    cyc(1'b1, 8'h82, 1'b0, 1'b0);
    checks++;
    if (dut_digits() !== 16'h0300) begin
      errors++; $display("FAIL load_priority: got %h expected %h", dut_digits(), 16'h0300);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'h82, 1'b1, 1'b1);
      checks++;
      if (dut_vec() !== exp_vec() || dut_digits() !== 16'h0300) begin
        errors++; $display("FAIL load_hold: got %h expected %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_count();
    cyc(1'b1, 8'h08, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b1, 1'b1);
    checks++;
    if (dut_digits() !== 16'h1000 || RUNNING !== 1'b1) begin
      errors++; $display("FAIL count_start: got %h expected %h", dut_vec(), exp_vec());
    end
    cyc(1'b1, 8'h00, 1'b1, 1'b1);
    checks++;
    if (dut_digits() !== 16'h0959) begin
      errors++; $display("FAIL count_borrow: got %h expected %h", dut_digits(), 16'h0959);
    end
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, 8'h00, 1'b1, 1'b1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL count_step: got %h expected %h", dut_vec(), exp_vec());
      end
    end
    checks++;
    if (dut_digits() !== 16'h0859) begin
      errors++; $display("FAIL count_60: got %h expected %h", dut_digits(), 16'h0859);
    end
    cyc(1'b0, 8'h01, 1'b1, 1'b1);
    checks++;
    if (dut_digits() !== 16'h0859 || RUNNING !== 1'b1) begin
      errors++; $display("FAIL count_ce_hold: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_pause();
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h04, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h00, 1'b1, 1'b1);
    cyc(1'b1, 8'h00, 1'b0, 1'b1);
    checks++;
    if (dut_digits() !== 16'h0457 || RUNNING !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL pause: got %h expected %h", dut_vec(), exp_vec());
    end
    cyc(1'b1, 8'h00, 1'b1, 1'b1);
    checks++;
    if (dut_digits() !== 16'h0457 || RUNNING !== 1'b1) begin
      errors++; $display("FAIL resume: got %h expected %h", dut_vec(), exp_vec());
    end
    cyc(1'b1, 8'h00, 1'b1, 1'b1);
    checks++;
    if (dut_digits() !== 16'h0456) begin
      errors++; $display("FAIL resume_tick: got %h expected %h", dut_digits(), 16'h0456);
    end
  endtask

  task automatic test_expiry();
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 51; i++) cyc(1'b1, 8'h00, 1'b1, 1'b1);
    checks++;
    if (dut_digits() !== 16'h0009 || LOW_TIME !== 1'b1) begin
      errors++; $display("FAIL low_time: got %h expected %h", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 8'h00, 1'b1, 1'b1);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL final_ticks: got %h expected %h", dut_vec(), exp_vec());
      end
    end
    checks++;
    if (dut_vec() !== 19'h00001) begin
      errors++; $display("FAIL expired: got %h expected %h", dut_vec(), 19'h00001);
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h00, 1'b1, 1'b1);
    checks++;
    if (dut_vec() !== 19'h00001) begin
      errors++; $display("FAIL expired_hold: got %h expected %h", dut_vec(), 19'h00001);
    end
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    checks++;
    if (dut_digits() !== 16'h0100 || EXPIRED !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reload_after_expiry: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_run_load_ignored();
    cyc(1'b1, 8'h02, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b1, 8'h00, 1'b1, 1'b1);
    checks++;
    if (dut_digits() !== 16'h0230) begin
      errors++; $display("FAIL run_0230: got %h expected %h", dut_digits(), 16'h0230);
    end
    cyc(1'b1, 8'h80, 1'b1, 1'b1);
    checks++;
    if (dut_digits() !== 16'h0229 || RUNNING !== 1'b1) begin
      errors++; $display("FAIL run_sel_ignored: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      logic ce, act, tk;
      logic [7:0] sel;
      ce  = ($urandom % 8) != 0;
      sel = (($urandom % 24) == 0) ? 8'($urandom) : 8'd0;
      act = ($urandom % 10) != 0;
      tk  = ($urandom % 2) != 0;
      cyc(ce, sel, act, tk);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_count();
    test_pause();
    test_expiry();
    test_run_load_ignored();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
